// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - serial pin in, validated byte strobe and status out
interface uart_rx_framer_if;
  logic        rx_pin;
  logic [7:0]  received_bits;
  logic        received_8_bits_flag;
  logic        framing_error;
  logic        rx_busy;
  logic [15:0] byte_count;

  // line driver / byte consumer side
  modport master (
    output rx_pin,
    input  received_bits,
    input  received_8_bits_flag,
    input  framing_error,
    input  rx_busy,
    input  byte_count
  );

  // receiver side
  modport slave (
    input  rx_pin,
    output received_bits,
    output received_8_bits_flag,
    output framing_error,
    output rx_busy,
    output byte_count
  );
endinterface

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 LSB-first receiver with glitch rejection and majority voting
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 864  // clocks per bit, must be at least 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_framer_if.slave  bus
);

  localparam int          HALF_BIT = CLKS_PER_BIT >> 1;
  localparam logic [15:0] START_TC = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_TC   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        sync_1;
  logic        rx_s;
  logic        hist_1;
  logic        hist_2;
  logic        maj;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  rx_byte;
  logic        byte_flag;
  logic        frame_err;
  logic        busy;
  logic [15:0] byte_cnt;

  // Bit decision: two of the current synchronized value and its two predecessors.
  assign maj = (rx_s & hist_1) | (rx_s & hist_2) | (hist_1 & hist_2);

  // Two-flop synchronizer followed by a two-deep history; idles high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      hist_1 <= 1'b1;
      hist_2 <= 1'b1;
    end else begin
      sync_1 <= bus.rx_pin;
      rx_s   <= sync_1;
      hist_1 <= rx_s;
      hist_2 <= hist_1;
    end
  end

  // Frame state machine; the bit counter restarts on every state entry so the
  // start sample lands mid start bit and each later sample one bit period on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      byte_flag <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      byte_flag <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= bit_cnt + 16'd1;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_cnt == START_TC) begin
            bit_cnt <= '0;
            if (maj) begin
              // Line back high by mid start bit: a glitch, drop it silently.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (bit_cnt == BIT_TC) begin
            bit_cnt        <= '0;
            shift[bit_idx] <= maj;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (bit_cnt == BIT_TC) begin
            bit_cnt <= '0;
            if (maj) begin
              // Leave at mid stop bit so an immediately following start is seen.
              rx_byte   <= shift;
              byte_flag <= 1'b1;
              byte_cnt  <= byte_cnt + 16'd1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // A held-low line reports one error, then waits here for idle.
          bit_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.received_bits        = rx_byte;
  assign bus.received_8_bits_flag = byte_flag;
  assign bus.framing_error        = frame_err;
  assign bus.rx_busy              = busy;
  assign bus.byte_count           = byte_cnt;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - directed and randomized frames checked against a byte-level model
module tb_uart_rx_framer;
  localparam int N  = 16;
  localparam int NP = 864;
  localparam int H  = N >> 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_rx_framer_if bus_a ();
  uart_rx_framer_if bus_p ();

  uart_rx_framer #(.CLKS_PER_BIT(N))  dut   (.clk(clk), .rst(rst), .bus(bus_a));
  uart_rx_framer #(.CLKS_PER_BIT(NP)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: what a correct receiver must have delivered
  logic [7:0]  exp_q[$];
  logic [15:0] exp_count = '0;
  logic [7:0]  exp_last  = '0;
  int          exp_err   = 0;

  // observations
  logic [7:0] obs_q[$];
  int         flag_cyc[$];
  int         err_n = 0;
  int         both_n = 0;
  int         long_n = 0;
  logic       prev_flag = 1'b0;
  logic       prev_err = 1'b0;
  int         flag_p_n = 0;
  int         err_p_n = 0;

  always @(negedge clk) begin
    if (bus_a.received_8_bits_flag) begin
      obs_q.push_back(bus_a.received_bits);
      flag_cyc.push_back(cyc);
    end
    if (bus_a.framing_error) err_n++;
    if (bus_a.received_8_bits_flag && bus_a.framing_error) both_n++;
    if ((bus_a.received_8_bits_flag && prev_flag) || (bus_a.framing_error && prev_err)) long_n++;
    prev_flag = bus_a.received_8_bits_flag;
    prev_err  = bus_a.framing_error;
    if (bus_p.received_8_bits_flag) flag_p_n++;
    if (bus_p.framing_error) err_p_n++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pin(input bit sel, input logic v);
    if (sel) bus_p.rx_pin = v;
    else     bus_a.rx_pin = v;
  endtask

  // One pin value per clock; optional one-cycle inversions timed to land on
  // each data sample edge after the two-flop delay; abort_at cuts the frame short.
  task automatic send_frame(input bit sel, input int n, input logic [7:0] b,
                            input logic stop, input bit noise, input int abort_at);
    logic [9:0] bits;
    int hh;
    bits = {stop, b, 1'b0};
    hh = n >> 1;
    for (int c = 0; c < 10 * n; c++) begin
      logic v;
      if (c == abort_at) return;
      v = bits[c / n];
      if (noise && c >= hh + n && c <= hh + 8 * n && ((c - hh) % n) == 0) v = ~v;
      set_pin(sel, v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_a(input logic [7:0] b, input logic stop, input bit noise);
    send_frame(1'b0, N, b, stop, noise, -1);
    if (stop) begin
      exp_q.push_back(b);
      exp_count = exp_count + 16'd1;
      exp_last  = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic hold_a(input logic v, input int c);
    bus_a.rx_pin = v;
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic verify_a(input string tag);
    check_val({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_val({tag, "_byte"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check_val({tag, "_count"}, bus_a.byte_count, exp_count);
    check_val({tag, "_last"}, bus_a.received_bits, exp_last);
    check_val({tag, "_errs"}, err_n, exp_err);
    check_val({tag, "_excl"}, both_n, 0);
    check_val({tag, "_pulse"}, long_n, 0);
  endtask

  initial begin
    int nf;
    bus_a.rx_pin = 1'b1;
    bus_p.rx_pin = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bits", bus_a.received_bits, 8'h00);
    check_val("rst_flag", bus_a.received_8_bits_flag, 1'b0);
    check_val("rst_err", bus_a.framing_error, 1'b0);
    check_val("rst_busy", bus_a.rx_busy, 1'b0);
    check_val("rst_count", bus_a.byte_count, 16'h0);
    check_val("rst_count_p", bus_p.byte_count, 16'h0);
    rst = 1'b0;
    hold_a(1'b1, 5);

    // production bit period
    send_frame(1'b1, NP, 8'h4F, 1'b1, 1'b0, -1);
    repeat (10) @(posedge clk);
    #1;
    check_val("prod_flags", flag_p_n, 1);
    check_val("prod_bits", bus_p.received_bits, 8'h4F);
    check_val("prod_count", bus_p.byte_count, 16'd1);
    check_val("prod_err", err_p_n, 0);

    // back-to-back frames
    flag_cyc.delete();
    tx_a(8'h4F, 1'b1, 1'b0);
    tx_a(8'h4B, 1'b1, 1'b0);
    hold_a(1'b1, N);
    check_val("b2b_flags", flag_cyc.size(), 2);
    if (flag_cyc.size() == 2) check_val("b2b_gap", flag_cyc[1] - flag_cyc[0], 10 * N);
    verify_a("b2b");

    // start-bit glitch: busy over the false start, back to idle at t0+H
    nf = flag_cyc.size();
    @(posedge clk);
    #1;
    bus_a.rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_a.rx_pin = 1'b1;
    repeat (H - 1) @(posedge clk);
    @(negedge clk);
    check_val("glitch_busy_hi", bus_a.rx_busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_val("glitch_busy_lo", bus_a.rx_busy, 1'b0);
    hold_a(1'b1, 2 * N);
    check_val("glitch_noflag", flag_cyc.size(), nf);
    tx_a(8'hA5, 1'b1, 1'b0);
    hold_a(1'b1, N);
    verify_a("glitch");

    // framing error then line held low
    tx_a(8'h3C, 1'b0, 1'b0);
    hold_a(1'b0, 40);
    check_val("ferr_break_busy", bus_a.rx_busy, 1'b1);
    verify_a("ferr");
    hold_a(1'b1, 2 * N);
    check_val("ferr_idle_busy", bus_a.rx_busy, 1'b0);
    tx_a(8'h55, 1'b1, 1'b0);
    hold_a(1'b1, N);
    verify_a("ferr_next");

    // spikes on every data sample edge
    tx_a(8'hC3, 1'b1, 1'b1);
    hold_a(1'b1, N);
    verify_a("noise");

    // random traffic with occasional bad stop bits and noise
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      tx_a(b, stop, bit'($urandom_range(0, 1)));
      if (!stop) begin
        hold_a(1'b0, $urandom_range(0, 20));
        hold_a(1'b1, $urandom_range(2, N));
      end else begin
        hold_a(1'b1, $urandom_range(0, N));
      end
    end
    hold_a(1'b1, N);
    verify_a("rand");

    // reset during data bit 4, line low across release
    send_frame(1'b0, N, 8'h0F, 1'b1, 1'b0, 5 * N + H);
    #2;
    rst = 1'b1;
    #1;
    exp_count = '0;
    exp_last  = '0;
    check_val("midrst_bits", bus_a.received_bits, 8'h00);
    check_val("midrst_count", bus_a.byte_count, 16'h0);
    check_val("midrst_flag", bus_a.received_8_bits_flag, 1'b0);
    check_val("midrst_err", bus_a.framing_error, 1'b0);
    check_val("midrst_busy", bus_a.rx_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_a(1'b0, 2);
    hold_a(1'b1, 12 * N);
    check_val("midrst_idle_busy", bus_a.rx_busy, 1'b0);
    verify_a("midrst");

    // count wrap
    tx_a(8'h21, 1'b1, 1'b0);
    hold_a(1'b1, N);
    force dut.byte_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.byte_cnt;
    exp_count = 16'hFFFF;
    tx_a(8'h96, 1'b1, 1'b0);
    hold_a(1'b1, N);
    verify_a("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Serial receive front end for the UART path. Converts the asynchronous `RX_PIN` line into validated 8-bit bytes for the bridge that loads RAM. Each good byte is presented on `RECEIVED_BITS` with a one-cycle `RECEIVED_8_BITS_FLAG` strobe. Frame format is 8N1, LSB first. The block provides start-bit glitch rejection, majority-vote sampling, framing-error reporting and a running good-byte count.

## Interface
- `CLKS_PER_BIT`, default 864: `MAIN_CLOCK` cycles per bit (N). Must be ≥ 8. H = N>>1.
- `MAIN_CLOCK` in 1: single system clock. All logic is on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `RX_PIN` in 1: serial input, idle high, asynchronous to `MAIN_CLOCK`.
- `RECEIVED_BITS` out 8: last good byte. Holds its value until the next good byte.
- `RECEIVED_8_BITS_FLAG` out 1: one-cycle pulse; `RECEIVED_BITS` is valid in the same cycle.
- `FRAMING_ERROR` out 1: one-cycle pulse when the stop bit is sampled low.
- `RX_BUSY` out 1: high in every state except IDLE.
- `BYTE_COUNT` out 16: number of good bytes since reset; wraps modulo 2^16.

## Operation
- **Input conditioning**
  - Two-flop synchronizer produces `rx_s`.
  - A 3-bit history register holds `rx_s` and its two previous values.
  - Every bit decision is the majority of these 3 values, taken at the sample edge.
- **Bit counter**
  - 16-bit counter, cleared on every state entry.
  - The sample edge is the edge where the counter reaches its terminal count: H-1 in START, N-1 in DATA and STOP.
- **States**
  - IDLE: when `rx_s`=0, go to START.
  - START: at the sample edge, majority 1 means a false start; return to IDLE with no flags. Majority 0 goes to DATA with bit index 0.
  - DATA: at each sample edge, write the majority into shift bit[index] (LSB first). After index 7, go to STOP.
  - STOP, majority 1 at the sample edge:
    - load `RECEIVED_BITS` and pulse `RECEIVED_8_BITS_FLAG`;
    - increment `BYTE_COUNT`;
    - go to IDLE.
    - Exit is at mid-stop-bit, so a back-to-back start bit is caught.
  - STOP, majority 0 at the sample edge:
    - pulse `FRAMING_ERROR`;
    - leave `RECEIVED_BITS` and `BYTE_COUNT` unchanged;
    - go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one error.
- **Flag rules**
  - `RECEIVED_8_BITS_FLAG` and `FRAMING_ERROR` are mutually exclusive.
  - Neither flag is ever high for more than one cycle.
  - There is no backpressure. The consumer must take the byte within N·9 cycles, before the next strobe overwrites it.
- **Reset**
  - `RESET` high at any time, including mid-frame, forces IDLE asynchronously.
  - The synchronizer and history registers are set to 1.
  - `RECEIVED_BITS`=0x00, `BYTE_COUNT`=0, and both flags and `RX_BUSY` are 0.
  - The partial frame is discarded.
  - After release, a line that is already low is treated as a start bit only once `rx_s` shows 0 in IDLE. No flag is raised for the partial frame.

## Timing
- `rx_s` follows `RX_PIN` after 2 edges.
- Let t0 be the edge where IDLE sees `rx_s`=0.
- Sample edges:
  - start bit: t0+H;
  - data bit k (k=0..7): t0+H+(k+1)·N;
  - stop bit: t0+H+9·N.
- All outputs are registered and update on the stop sample edge. The flag is high from that edge to the next.
- Latency from the RX_PIN start falling edge to the flag is about H+9N+2 cycles.
- `RX_BUSY` rises on the edge after t0. For a good frame it falls on the stop sample edge.
- Sample-point tolerance is ±H−2 cycles per frame, i.e. clock mismatch up to about 5% at N=864.

## Test plan
- **Good byte, production parameter.** N=864; frame start 0, bits 1,1,1,1,0,0,1,0, stop 1 (LSB first). Expect `RECEIVED_BITS`=0x4F, one flag pulse, `BYTE_COUNT`=1, no error.
- **Back-to-back frames.** N=16; 0x4F then 0x4B sent with no idle gap (stop bit followed directly by start). Expect two flags 10·N cycles apart, bytes 0x4F and 0x4B in order, `BYTE_COUNT`=2.
- **Start-bit glitch.** N=16; `RX_PIN` low for 3 cycles, then high. Expect the block to return to IDLE at t0+8 with `RX_BUSY` low and no flags; a following 0xA5 frame is received correctly.
- **Framing error.** N=16; send 0x3C with the stop bit low, then hold low 40 cycles. Expect exactly one `FRAMING_ERROR` pulse, `RECEIVED_BITS` keeping its prior value, `BYTE_COUNT` unchanged, and the block in BREAK until the line goes high. A subsequent 0x55 frame is received correctly.
- **Mid-bit noise.** N=16; a 1-cycle inverted spike placed exactly on each data sample edge of 0xC3. Majority voting still yields 0xC3.
- **Reset mid-frame and count wrap.**
  - Assert `RESET` during data bit 4. All outputs go to reset values within the same cycle, and no flag follows.
  - Preload-by-traffic 65535 bytes (or force the count), then send one byte. Expect `BYTE_COUNT` to wrap to 0.
